// File: rtl/prime_check_core.sv
// Trial-division primality core behind a start/done handshake.
// Each candidate divisor goes through one square test, then W bit-serial restoring remainder steps.
module prime_check_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_port,
  input  logic [DATA_WIDTH-1:0] n,
  output logic                  done_port,
  output logic                  return_port
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned IW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_result_next;

  logic [W-1:0]    r_nr;
  logic [W-1:0]    r_d;
  logic [W-1:0]    r_rem;
  logic [IW-1:0]   r_i;
  logic            r_done;
  logic            r_result;

  logic [2*W-1:0]  w_dd;
  logic [2*W-1:0]  w_nr_ext;
  logic [W:0]      w_rem_shift;
  logic [W:0]      w_rem_next;
  logic            w_ge;
  logic            w_last_step;

  // The square is formed at double width so the largest operand cannot overflow it.
  assign w_dd        = {{W{1'b0}}, r_d} * {{W{1'b0}}, r_d};
  assign w_nr_ext    = {{W{1'b0}}, r_nr};
  assign w_rem_shift = {r_rem, r_nr[r_i]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_d});
  assign w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_d}) : w_rem_shift;
  assign w_last_step = (r_i == IW'(0));

  assign done_port   = r_done;
  assign return_port = r_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_result_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_port) begin
          w_state_next = (n < W'(2)) ? S_DONE : S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_dd > w_nr_ext) begin
          w_state_next  = S_DONE;
          w_result_next = 1'b1;
        end else begin
          w_state_next = S_DIV;
        end
      end
      S_DIV: begin
        if (w_last_step) begin
          w_state_next = (w_rem_next == '0) ? S_DONE : S_CHECK;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and registered handshake outputs; done rises on the edge that enters DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nr     <= '0;
      r_d      <= '0;
      r_rem    <= '0;
      r_i      <= '0;
      r_done   <= 1'b0;
      r_result <= 1'b0;
    end else begin
      r_done <= (w_state_next == S_DONE);
      if (w_state_next == S_DONE) begin
        r_result <= w_result_next;
      end
      case (r_state)
        S_IDLE: begin
          if (start_port) begin
            r_nr <= n;
            r_d  <= W'(2);
          end
        end
        S_CHECK: begin
          r_rem <= '0;
          r_i   <= IW'(W - 1);
        end
        S_DIV: begin
          r_rem <= w_rem_next[W-1:0];
          r_i   <= r_i - IW'(1);
          if (w_last_step) begin
            r_d <= r_d + W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_check_core.sv
// Directed bench for prime_check_core: result, latency, busy, back-to-back and reset behaviour.
module tb_prime_check_core;

  localparam int unsigned W = 32;

  logic         clock;
  logic         reset;
  logic         start_port;
  logic [W-1:0] n;
  logic         done_port;
  logic         return_port;

  int checks;
  int errors;

  prime_check_core #(.DATA_WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_port  (start_port),
    .n           (n),
    .done_port   (done_port),
    .return_port (return_port)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one operation from IDLE and measure edges until done_port is seen.
  task automatic run_op(input string tag, input logic [W-1:0] val,
                        input logic exp_ret, input int exp_lat);
    int lat;
    @(negedge clock);
    start_port = 1'b1;
    n          = val;
    @(posedge clock);
    lat = 1;
    #1;
    start_port = 1'b0;
    while (!done_port && lat < 2000) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_done_seen"}, 64'(done_port), 64'(1));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_return"}, 64'(return_port), 64'(exp_ret));
    @(posedge clock);
    #1;
    check({tag, "_pulse_one_cycle"}, 64'(done_port), 64'(0));
    check({tag, "_return_held"}, 64'(return_port), 64'(exp_ret));
  endtask

  initial begin
    int pulses;
    int first_lat;
    logic first_ret;
    int lat;

    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    start_port = 1'b0;
    n          = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_done", 64'(done_port), 64'(0));
    check("reset_return", 64'(return_port), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // Idle with no start must never pulse done.
    pulses = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (done_port) pulses++;
    end
    check("idle_no_done", 64'(pulses), 64'(0));

    run_op("n0", 32'd0, 1'b0, 1);
    run_op("n1", 32'd1, 1'b0, 1);
    run_op("n2", 32'd2, 1'b1, 2);
    run_op("n3", 32'd3, 1'b1, 2);

    // Async reset mid-cycle clears the held prime result immediately.
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_done", 64'(done_port), 64'(0));
    check("async_reset_return", 64'(return_port), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    run_op("n4", 32'd4, 1'b0, 34);
    run_op("n7", 32'd7, 1'b1, 35);
    run_op("n25", 32'd25, 1'b0, 133);
    run_op("n97", 32'd97, 1'b1, 266);

    // Busy protection: a second start during the n=97 run is ignored.
    @(negedge clock);
    start_port = 1'b1;
    n          = 32'd97;
    @(posedge clock);
    lat = 1;
    #1;
    start_port = 1'b0;
    pulses    = 0;
    first_lat = 0;
    first_ret = 1'b0;
    while (lat < 350) begin
      if (lat == 5) begin
        start_port = 1'b1;
        n          = 32'd4;
      end else begin
        start_port = 1'b0;
      end
      @(posedge clock);
      #1;
      lat++;
      if (done_port) begin
        pulses++;
        if (pulses == 1) begin
          first_lat = lat;
          first_ret = return_port;
        end
      end
    end
    start_port = 1'b0;
    check("busy_pulse_count", 64'(pulses), 64'(1));
    check("busy_latency", 64'(first_lat), 64'(266));
    check("busy_return", 64'(first_ret), 64'(1));

    // Back-to-back: start held high with n=3 pulses every third edge.
    @(negedge clock);
    start_port = 1'b1;
    n          = 32'd3;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("b2b_done_c%0d", c), 64'(done_port), 64'((c % 3) == 2));
      if ((c % 3) == 2) begin
        check($sformatf("b2b_return_c%0d", c), 64'(return_port), 64'(1));
      end
    end
    start_port = 1'b0;
    repeat (3) @(posedge clock);

    // Reset in the middle of a division abandons the operation silently.
    @(negedge clock);
    start_port = 1'b1;
    n          = 32'd97;
    @(posedge clock);
    lat = 1;
    #1;
    start_port = 1'b0;
    while (lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    reset = 1'b1;
    #1;
    check("mid_div_reset_done", 64'(done_port), 64'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (300) begin
      @(posedge clock);
      #1;
      if (done_port) pulses++;
    end
    check("mid_div_no_pulse", 64'(pulses), 64'(0));
    run_op("n9", 32'd9, 1'b0, 67);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
